traffic_controller: RTL and testbench
=====================================

TRAFFIC_CONTROLLER -- requirements
Module: traffic_controller

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port ped_req, input, 1 bit: pedestrian button request, level or pulse, sampled every cycle.
REQ-004 SHALL have port enable, input, 1 bit: phase-advance strobe from the timing decoder, which decodes counter and PED combinationally.
REQ-005 SHALL have port counter, output, 6 bits: phase-cycle count, registered.
REQ-006 SHALL have port PED, output, 1 bit: pedestrian-cycle mode for the current cycle, registered.
REQ-007 SHALL have port mainTraffic, output, 3 bits: main-road lamp, one-hot {red, yellow, green}, where 3'b100 is red, 3'b010 is yellow and 3'b001 is green.
REQ-008 SHALL have port sideTraffic, output, 3 bits: side-road lamp, same encoding as mainTraffic.
REQ-009 SHALL have port walk, output, 1 bit: pedestrian WALK lamp.

Function
REQ-010 SHALL implement a registered FSM with seven states:
- MG: main green, side red
- MY: main yellow, side red
- AR: all red
- SG: main red, side green
- SY: main red, side yellow
- WK: all red, walk=1
- FLT: fault, all red
REQ-011 SHALL drive mainTraffic, sideTraffic and walk as pure decodes of the current state; walk=1 only in WK.
REQ-012 SHALL increment counter by 1 every cycle, except on a wrap cycle (REQ-015) or when in FLT.
REQ-013 SHALL use the following transitions when PED=0, each taken at the clock edge where enable=1 in the given state:
- MG to MY
- MY to AR
- AR to SG
- SG to SY
- SY to MG (wrap)
- expected enable counts: 15, 17, 19, 27, 29
REQ-014 SHALL use the following transitions when PED=1, each taken at the clock edge where enable=1 in the given state:
- MG to MY
- MY to AR
- AR to SG
- SG to SY
- SY to WK
- WK to MG (wrap)
- expected enable counts: 11, 13, 15, 21, 23, 33
REQ-015 SHALL define a wrap cycle as the cycle that takes the final transition into MG; on that edge counter SHALL load 0 (not 1).
REQ-016 SHALL latch a pending flag whenever ped_req=1; the flag holds until consumed.
REQ-017 SHALL update PED only on a wrap edge: PED <= pending OR ped_req; pending SHALL clear on the same edge.
REQ-018 SHALL keep PED constant for an entire cycle; ped_req mid-cycle affects only the next cycle.
REQ-019 SHALL ignore enable=1 while the FSM is in FLT.
REQ-020 SHALL treat enable as a one-cycle strobe; if enable stays high on consecutive cycles, each high cycle advances exactly one state.
REQ-021 SHALL enter FLT when counter==63 and enable=0 (a missed strobe, so no wrap): FLT is entered on the next edge and counter holds 63.
REQ-022 SHALL leave FLT only through rst.
REQ-023 SHALL NOT let counter wrap past 63 by natural increment.
REQ-024 SHALL give rst priority over every other event, including a simultaneous enable or ped_req.

Reset
REQ-025 SHALL, on a clk edge with rst=1, set state to MG, counter=0, PED=0, pending=0.
REQ-026 SHALL therefore drive mainTraffic=3'b001, sideTraffic=3'b100 and walk=0 in the first cycle after reset.
REQ-027 SHALL apply reset identically when asserted mid-cycle, in any state including FLT and WK.
REQ-028 SHALL discard on reset any ped_req sampled in the same cycle as rst=1.

Verification
REQ-029 SHALL cover the normal cycle: drive enable as decoded from counter/PED, no ped_req.
- transitions at counts 15, 17, 19, 27, 29
- counter reads 0 in the cycle after the count-29 edge
- mainTraffic sequence: 001, 010, 100, 100, 100, 001
REQ-030 SHALL cover a pedestrian request:
- pulse ped_req at counter=5
- PED stays 0 until the wrap, then becomes 1
- the next cycle transitions at 11, 13, 15, 21, 23, 33
- walk=1 in counts 24 through 33 only
- PED returns to 0 after that cycle's wrap
REQ-031 SHALL cover a request on the wrap cycle: ped_req=1 exactly on the count-29 wrap edge; PED=1 in the very next cycle and pending=0.
REQ-032 SHALL cover a missed strobe: hold enable=0 from reset.
- counter reaches 63
- FSM enters FLT, both lamps 3'b100, counter frozen at 63
- a later enable pulse has no effect
REQ-033 SHALL cover reset during WK: assert rst at PED=1, counter=28; the next cycle shows MG, counter=0, PED=0, walk=0.
REQ-034 SHALL cover a stuck-high strobe: hold enable=1 for 3 cycles starting in MG; the state sequence is MY, AR, SG, one state per cycle, and counter keeps incrementing.

Source files
------------

// File: rtl/traffic_controller.sv
// Main/side-road traffic light controller with an optional pedestrian WALK
// phase, an enable-strobed phase sequencer and a missed-strobe fault trap.
module traffic_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic       ped_req,
  input  logic       enable,
  output logic [5:0] counter,
  output logic       PED,
  output logic [2:0] mainTraffic,
  output logic [2:0] sideTraffic,
  output logic       walk
);

  typedef enum logic [2:0] {MG, MY, AR, SG, SY, WK, FLT} state_t;

  localparam logic [2:0] RED     = 3'b100;
  localparam logic [2:0] YELLOW  = 3'b010;
  localparam logic [2:0] GREEN   = 3'b001;
  localparam logic [5:0] CNT_MAX = 6'd63;

  state_t     state, state_nxt;
  logic [5:0] counter_nxt;
  logic       ped_nxt;
  logic       pending, pending_nxt;
  logic       wrap;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= MG;
      counter <= '0;
      PED     <= 1'b0;
      pending <= 1'b0;
    end else begin
      state   <= state_nxt;
      counter <= counter_nxt;
      PED     <= ped_nxt;
      pending <= pending_nxt;
    end
  end

  // NOTE: every signal gets a default before any branch, so no path leaves a
  // combinational output unassigned (which would infer a latch).
  always_comb begin
    state_nxt   = state;
    counter_nxt = counter;
    ped_nxt     = PED;
    pending_nxt = pending | ped_req;
    wrap        = 1'b0;

    if (state != FLT) begin
      if (enable) begin
        case (state)
          MG:      state_nxt = MY;
          MY:      state_nxt = AR;
          AR:      state_nxt = SG;
          SG:      state_nxt = SY;
          SY:      state_nxt = PED ? WK : MG;
          WK:      state_nxt = MG;
          default: state_nxt = FLT;
        endcase
        wrap = (state_nxt == MG);
      end else if (counter == CNT_MAX) begin
        // The decoder never let the count run this far: a strobe was missed.
        state_nxt = FLT;
      end

      if (wrap) begin
        counter_nxt = '0;
        ped_nxt     = pending | ped_req;
        pending_nxt = 1'b0;
      end else if (counter != CNT_MAX) begin
        counter_nxt = counter + 6'd1;
      end
    end
  end

  always_comb begin
    mainTraffic = RED;
    sideTraffic = RED;
    walk        = 1'b0;
    case (state)
      MG: mainTraffic = GREEN;
      MY: mainTraffic = YELLOW;
      SG: sideTraffic = GREEN;
      SY: sideTraffic = YELLOW;
      WK: walk        = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_traffic_controller.sv
// Self-checking bench for traffic_controller: a behavioural model pushes the
// expected outputs per driven cycle into a scoreboard that is popped after the edge.
module tb_traffic_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ped_req = 1'b0;
  logic       enable = 1'b0;
  logic [5:0] counter;
  logic       PED;
  logic [2:0] mainTraffic;
  logic [2:0] sideTraffic;
  logic       walk;

  always #5 clk = ~clk;

  traffic_controller dut (
    .clk         (clk),
    .rst         (rst),
    .ped_req     (ped_req),
    .enable      (enable),
    .counter     (counter),
    .PED         (PED),
    .mainTraffic (mainTraffic),
    .sideTraffic (sideTraffic),
    .walk        (walk)
  );

  typedef enum logic [2:0] {T_MG, T_MY, T_AR, T_SG, T_SY, T_WK, T_FLT} tstate_t;

  typedef struct packed {
    logic [5:0] cnt;
    logic       ped;
    logic       pend;
    logic [2:0] main_l;
    logic [2:0] side_l;
    logic       walk;
  } exp_t;

  exp_t    sb[$];
  int      n_checks = 0;
  int      n_errors = 0;

  tstate_t ms    = T_MG;
  int      mc    = 0;
  bit      mp    = 1'b0;
  bit      mpend = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Timing decoder: enable strobes at the phase-end counts of each cycle type.
  function automatic bit dec(input int c, input bit p);
    if (p) return (c == 11 || c == 13 || c == 15 || c == 21 || c == 23 || c == 33);
    return (c == 15 || c == 17 || c == 19 || c == 27 || c == 29);
  endfunction

  function automatic logic [2:0] main_of(input tstate_t s);
    case (s)
      T_MG:    return 3'b001;
      T_MY:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] side_of(input tstate_t s);
    case (s)
      T_SG:    return 3'b001;
      T_SY:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  task automatic model(input bit r, input bit p, input bit e);
    tstate_t nx;
    if (r) begin
      ms = T_MG; mc = 0; mp = 1'b0; mpend = 1'b0;
    end else if (ms == T_FLT) begin
      mpend = mpend | p;
    end else if (!e) begin
      if (mc == 63) ms = T_FLT;
      else mc = mc + 1;
      mpend = mpend | p;
    end else begin
      case (ms)
        T_MG:    nx = T_MY;
        T_MY:    nx = T_AR;
        T_AR:    nx = T_SG;
        T_SG:    nx = T_SY;
        T_SY:    nx = mp ? T_WK : T_MG;
        T_WK:    nx = T_MG;
        default: nx = T_FLT;
      endcase
      if (nx == T_MG) begin
        mp = mpend | p; mpend = 1'b0; mc = 0;
      end else begin
        mpend = mpend | p;
        if (mc < 63) mc = mc + 1;
      end
      ms = nx;
    end
  endtask

  task automatic cycle(input bit r, input bit p, input bit e);
    exp_t x;
    exp_t y;
    @(negedge clk);
    rst = r; ped_req = p; enable = e;
    model(r, p, e);
    x.cnt    = 6'(mc);
    x.ped    = mp;
    x.pend   = mpend;
    x.main_l = main_of(ms);
    x.side_l = side_of(ms);
    x.walk   = (ms == T_WK);
    sb.push_back(x);
    @(posedge clk);
    #1;
    y = sb.pop_front();
    check("counter", {26'd0, counter}, {26'd0, y.cnt});
    check("ped", {31'd0, PED}, {31'd0, y.ped});
    check("pending", {31'd0, dut.pending}, {31'd0, y.pend});
    check("main", {29'd0, mainTraffic}, {29'd0, y.main_l});
    check("side", {29'd0, sideTraffic}, {29'd0, y.side_l});
    check("walk", {31'd0, walk}, {31'd0, y.walk});
  endtask

  // Decoder-driven cycles; ped_req is pulsed once when the count equals ped_at.
  task automatic run(input int n, input int ped_at);
    bit used = 1'b0;
    for (int i = 0; i < n; i++) begin
      bit p = (!used && mc == ped_at);
      if (p) used = 1'b1;
      cycle(1'b0, p, dec(mc, mp));
    end
  endtask

  task automatic run_until(input int target, input bit pd);
    int guard = 0;
    while (!(mc == target && mp == pd) && guard < 200) begin
      cycle(1'b0, 1'b0, dec(mc, mp));
      guard++;
    end
    if (guard >= 200) check("run_until_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    // Reset and first-cycle lamps
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    check("rst_main", {29'd0, mainTraffic}, 32'b001);
    check("rst_side", {29'd0, sideTraffic}, 32'b100);

    // Normal cycle, then a pedestrian request pulsed at count 5
    run(31, -1);
    run(66, 5);

    // Request arriving exactly on the wrap edge takes effect immediately
    run_until(29, 1'b0);
    cycle(1'b0, 1'b1, dec(mc, mp));
    check("wrap_req_ped", {31'd0, PED}, 32'd1);
    check("wrap_req_pend", {31'd0, dut.pending}, 32'd0);
    check("wrap_req_cnt", {26'd0, counter}, 32'd0);

    // Reset while in WK
    run_until(28, 1'b1);
    check("wk_walk", {31'd0, walk}, 32'd1);
    cycle(1'b1, 1'b0, dec(mc, mp));
    check("wk_rst_walk", {31'd0, walk}, 32'd0);

    // Stuck-high strobe: one state per cycle
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    check("stuck_side_green", {29'd0, sideTraffic}, 32'b001);
    check("stuck_cnt", {26'd0, counter}, 32'd3);

    // Reset wins over simultaneous enable and ped_req
    cycle(1'b1, 1'b1, 1'b1);

    // Missed strobe: count runs to 63, then FLT traps and ignores enable
    for (int i = 0; i < 66; i++) cycle(1'b0, 1'b0, 1'b0);
    check("flt_main", {29'd0, mainTraffic}, 32'b100);
    check("flt_cnt", {26'd0, counter}, 32'd63);
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);

    // Reset out of FLT, then a normal run
    cycle(1'b1, 1'b0, 1'b0);
    run(32, -1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
